// File: rtl/pc_sequencer_pkg.sv
// Shared types and default vectors for the fetch-stage PC sequencer.
package pc_pkg;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BRANCH,
    SRC_JUMP,
    SRC_CALL,
    SRC_RET,
    SRC_TRAP
  } pc_src_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0180;

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the fetch controller and the PC sequencer.
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             stall;
  logic             trap;
  logic             jump;
  logic             call;
  logic             ret;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_offset;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic             redirect;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_underflow;

  modport master (
    output stall, trap, jump, call, ret, branch_taken, branch_offset, jump_target,
    input  pc, pc_plus, redirect, ras_empty, ras_full, ras_underflow
  );

  modport slave (
    input  stall, trap, jump, call, ret, branch_taken, branch_offset, jump_target,
    output pc, pc_plus, redirect, ras_empty, ras_full, ras_underflow
  );

endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module pc_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] WP_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] stack [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW:0]      count;

  // Storage is not reset; count gates every read that matters.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      stack[wp] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      count <= '0;
    end else if (push) begin
      wp <= wp + WP_ONE;
      if (count != CNT_MAX) begin
        count <= count + CNT_ONE;
      end
    end else if (pop) begin
      wp <= wp - WP_ONE;
      if (count != '0) begin
        count <= count - CNT_ONE;
      end
    end
  end

  assign top   = stack[wp - WP_ONE];
  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with prioritised next-PC selection and a return stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               INSN_BYTES   = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(DEFAULT_TRAP_VECTOR),
  parameter int               RAS_DEPTH    = 4
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  localparam int SHIFT = $clog2(INSN_BYTES);

  pc_src_e          src;
  logic             hold;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_push;
  logic             ras_pop;
  logic             redirect_q;
  logic             underflow_q;

  // Trap beats stall; a call dominates a simultaneous jump.
  always_comb begin
    src  = SRC_SEQ;
    hold = 1'b0;
    if (bus.trap) begin
      src = SRC_TRAP;
    end else if (bus.stall) begin
      hold = 1'b1;
    end else if (bus.call) begin
      src = SRC_CALL;
    end else if (bus.jump) begin
      src = SRC_JUMP;
    end else if (bus.ret) begin
      src = SRC_RET;
    end else if (bus.branch_taken) begin
      src = SRC_BRANCH;
    end
  end

  assign pc_plus  = pc_q + WIDTH'(INSN_BYTES);
  assign ras_push = (src == SRC_CALL);
  assign ras_pop  = (src == SRC_RET) && !ras_empty;

  always_comb begin
    pc_next = pc_plus;
    if (hold) begin
      pc_next = pc_q;
    end else begin
      case (src)
        SRC_TRAP:   pc_next = TRAP_VECTOR;
        SRC_CALL,
        SRC_JUMP:   pc_next = bus.jump_target;
        SRC_RET:    pc_next = ras_empty ? pc_plus : ras_top;
        SRC_BRANCH: pc_next = pc_plus + (bus.branch_offset << SHIFT);
        default:    pc_next = pc_plus;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_VECTOR;
      redirect_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_next;
      redirect_q  <= !hold && (src != SRC_SEQ) && !((src == SRC_RET) && ras_empty);
      underflow_q <= (src == SRC_RET) && ras_empty;
    end
  end

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign bus.pc            = pc_q;
  assign bus.pc_plus       = pc_plus;
  assign bus.redirect      = redirect_q;
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_full      = ras_full;
  assign bus.ras_underflow = underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a reference model queues expectations per edge.
module tb_pc_sequencer;
  import pc_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic        redirect;
    logic        underflow;
    logic        empty;
    logic        full;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t        sb[$];
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];

  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(32)) bus();

  pc_sequencer #(
    .WIDTH        (32),
    .INSN_BYTES   (4),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0180),
    .RAS_DEPTH    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of requests, predict the post-edge state, then compare.
  task automatic step(input logic r, input logic st, input logic tr, input logic j,
                      input logic c, input logic rt, input logic b,
                      input logic [31:0] off, input logic [31:0] tgt);
    exp_t        e;
    logic [31:0] mp;
    rst = r;
    bus.stall = st; bus.trap = tr; bus.jump = j; bus.call = c;
    bus.ret = rt; bus.branch_taken = b; bus.branch_offset = off; bus.jump_target = tgt;
    mp = m_pc + 32'd4;
    e.redirect = 1'b0;
    e.underflow = 1'b0;
    if (r) begin
      m_pc = 32'h0;
      m_stack.delete();
    end else if (tr) begin
      m_pc = 32'h180;
      e.redirect = 1'b1;
    end else if (st) begin
      m_pc = m_pc;
    end else if (c) begin
      m_stack.push_back(mp);
      if (m_stack.size() > 4) void'(m_stack.pop_front());
      m_pc = tgt;
      e.redirect = 1'b1;
    end else if (j) begin
      m_pc = tgt;
      e.redirect = 1'b1;
    end else if (rt) begin
      if (m_stack.size() > 0) begin
        m_pc = m_stack.pop_back();
        e.redirect = 1'b1;
      end else begin
        m_pc = mp;
        e.underflow = 1'b1;
      end
    end else if (b) begin
      m_pc = mp + (off * 32'd4);
      e.redirect = 1'b1;
    end else begin
      m_pc = mp;
    end
    e.pc = m_pc;
    e.empty = (m_stack.size() == 0);
    e.full = (m_stack.size() == 4);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pc", bus.pc, e.pc);
    chk("redirect", 32'(bus.redirect), 32'(e.redirect));
    chk("underflow", 32'(bus.ras_underflow), 32'(e.underflow));
    chk("ras_empty", 32'(bus.ras_empty), 32'(e.empty));
    chk("ras_full", 32'(bus.ras_full), 32'(e.full));
    chk("pc_plus", bus.pc_plus, e.pc + 32'd4);
    @(negedge clk);
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    m_pc = 32'h0;
    bus.stall = 0; bus.trap = 0; bus.jump = 0; bus.call = 0;
    bus.ret = 0; bus.branch_taken = 0; bus.branch_offset = '0; bus.jump_target = '0;
    @(negedge clk);

    step(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("reset_pc", bus.pc, DEFAULT_RESET_VECTOR);
    seq(3);
    chk("free_run_pc", bus.pc, 32'hC);

    step(0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h100);
    step(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'h0);
    chk("branch_back_pc", bus.pc, 32'h0FC);
    seq(1);

    step(0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h10);
    step(0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h400);
    step(0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h800);
    step(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    chk("ret1_pc", bus.pc, 32'h404);
    step(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    chk("ret2_pc", bus.pc, 32'h14);

    for (int i = 1; i <= 5; i++) step(0, 0, 0, 0, 1, 0, 0, 32'h0, 32'(i) << 12);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    chk("ret5_underflow_pc", bus.pc, 32'h1008);

    step(0, 1, 0, 1, 0, 0, 0, 32'h0, 32'h300);
    step(0, 1, 1, 1, 0, 0, 0, 32'h0, 32'h300);
    chk("trap_over_stall_pc", bus.pc, DEFAULT_TRAP_VECTOR);
    step(0, 1, 0, 1, 0, 0, 0, 32'h0, 32'h300);
    step(0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h300);

    step(0, 0, 0, 1, 1, 0, 0, 32'h0, 32'h500);
    step(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    chk("jump_call_ret_pc", bus.pc, 32'h304);

    step(0, 0, 0, 1, 0, 0, 0, 32'h0, 32'hFFFF_FFFC);
    seq(1);
    chk("wrap_pc", bus.pc, 32'h0);
    step(0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h40);
    step(1, 0, 0, 0, 1, 0, 0, 32'h0, 32'h80);
    chk("rst_call_empty", 32'(bus.ras_empty), 32'h1);

    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0), 32'($signed($urandom_range(0, 15)) - 8),
           {$urandom_range(0, 32'hFFFF), 2'b00});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the datapath fetch stage. It owns the PC register and selects the next PC from five sources: sequential, taken branch, jump/call, return, and trap vector. A small circular return-address stack (RAS) is built in. It drives `redirect` so downstream stages can flush after any non-sequential fetch.

## Interface
Parameters:
- `WIDTH`, 32, address width in bits
- `INSN_BYTES`, 4, sequential increment; a power of two ≥ 1
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded by reset
- `TRAP_VECTOR`, 32'h0000_0180, PC value loaded by trap
- `RAS_DEPTH`, 4, number of return-stack entries; a power of two ≥ 2

Ports (clock and reset first). One clock; reset is synchronous and active-high.
- `clk` in 1: rising-edge clock
- `rst` in 1: synchronous active-high reset
- `stall` in 1: hold the PC and the RAS this cycle
- `trap` in 1: load TRAP_VECTOR
- `jump` in 1: load `jump_target`
- `call` in 1: load `jump_target` and push `pc_plus`
- `ret` in 1: load the RAS top and pop it
- `branch_taken` in 1: load `pc_plus + (branch_offset << log2(INSN_BYTES))`
- `branch_offset` in WIDTH: signed offset, in instructions
- `jump_target` in WIDTH: absolute target address
- `pc` out WIDTH: current PC (registered)
- `pc_plus` out WIDTH: `pc + INSN_BYTES` (combinational)
- `redirect` out 1: registered; high for exactly the cycle after a non-sequential PC load
- `ras_empty` out 1: RAS count == 0
- `ras_full` out 1: RAS count == RAS_DEPTH
- `ras_underflow` out 1: registered one-cycle pulse after a `ret` taken with the RAS empty

## Operation
- Source priority per cycle: `rst` > `trap` > `stall` > `jump`/`call` > `ret` > `branch_taken` > sequential.
  - Only the winning source acts; lower requests are ignored.
  - `jump` and `call` together behave as `call`.
- `trap` overrides `stall`. It does not touch the RAS.
- `stall` without `trap`:
  - `pc` holds and the RAS is unchanged.
  - `redirect` and `ras_underflow` go low the next cycle.
- `call`:
  - `pc <= jump_target`.
  - Push `pc_plus` at the write pointer; `wp <= wp+1` mod RAS_DEPTH.
  - `count` is incremented, saturating at RAS_DEPTH.
  - Pushing while full overwrites the oldest entry; `count` stays RAS_DEPTH.
- `ret` with count > 0: `pc <= ras[wp-1]`, `wp <= wp-1`, `count <= count-1`.
- `ret` with count == 0:
  - `pc <= pc_plus`; RAS unchanged.
  - `ras_underflow` = 1 next cycle.
  - `redirect` = 0, because the load is sequential.
- Branch target: `pc_plus + (branch_offset << log2(INSN_BYTES))`.
- Arithmetic: all PC arithmetic is unsigned modulo 2^WIDTH. Wrap-around at the top of memory is legal and silent.
- `redirect` next cycle = 1 iff the winning source was trap, jump, call, ret (non-empty) or branch_taken. Otherwise 0.
- Reset values:
  - `pc` = RESET_VECTOR
  - `wp` = 0, `count` = 0, so `ras_empty` = 1 and `ras_full` = 0
  - `redirect` = 0, `ras_underflow` = 0
  - RAS contents are don't-care.
- Reset mid-operation: any simultaneous request is discarded and the RAS is emptied in the same edge.

## Timing
- Latency: exactly one edge for every source. The request is sampled at edge N; the new `pc` is visible after edge N.
- `pc_plus`, `ras_empty` and `ras_full` are combinational from registers only. There is no input-to-output combinational path.
- `redirect` and `ras_underflow` assert in the same cycle as the new `pc` and last one cycle, unless re-triggered.
- A push followed by a pop on back-to-back cycles returns the pushed value; the RAS write is visible on the next edge.
- Held `stall` for K cycles gives K cycles of constant `pc`; the request pending at stall release acts on the first unstalled edge.

## Structure
- Shared package `pc_pkg`:
  - `pc_src_e` enum: `SRC_SEQ`, `SRC_BRANCH`, `SRC_JUMP`, `SRC_CALL`, `SRC_RET`, `SRC_TRAP`.
  - Default vector constants.
- Sub-module `pc_ras`:
  - Holds the circular stack storage, `wp`, `count`, `push`/`pop` inputs, the `top` output, and the `empty`/`full` outputs.
  - Push has priority over pop; it never happens in practice because the sequencer makes the two one-hot.
- The top level contains the priority encoder, target adders and the PC register.

## Test plan
- Reset, then 3 free-running cycles → `pc` = 0x0, 0x4, 0x8, 0xC; `redirect` = 0 throughout.
- At `pc` = 0x100, `branch_taken` with offset -2 → `pc` = 0x0FC, `redirect` = 1 for one cycle.
- `call` to 0x400 from 0x10, then `call` to 0x800, then `ret`, `ret` → `pc` sequence 0x400, 0x800, 0x404, 0x14; `ras_empty` = 1 at the end.
- Five calls with RAS_DEPTH=4, then five rets → first four rets return the newest four addresses in reverse order. Fifth ret gives `pc_plus` and `ras_underflow` = 1.
- `stall` held 3 cycles with `jump` asserted, and `trap` arriving on the 2nd stalled cycle → `pc` = 0x180 after that edge; `jump` ignored.
- `pc` = 0xFFFF_FFFC, sequential step → `pc` = 0x0. Then `rst` together with `call` → `pc` = RESET_VECTOR and `ras_empty` = 1.
